soc_gpio_monitor: RTL and testbench
===================================

SOC_GPIO_MONITOR -- requirements
Module: soc_gpio_monitor

Interface
REQ-001 Parameter GPIO_W, default 32: width of the observed GPIO bus.
REQ-002 Parameter STOP_CODE, default 32'hFFFF_FFFF (GPIO_W bits): pattern that ends the run.
REQ-003 Parameter STOP_MASK, default all-ones (GPIO_W bits): bits compared against STOP_CODE.
REQ-004 Parameter FIFO_DEPTH, default 8, power of two >= 2: event FIFO entries.
REQ-005 Parameter TS_W, default 32: timestamp/cycle-counter width.
REQ-006 Parameter TIMEOUT_CYCLES, default 1_000_000: idle cycles before timeout; 0 disables timeout.
REQ-007 clk  input  1  single clock; all state updates on the rising edge.
REQ-008 rst  input  1  reset, synchronous and active-high.
REQ-009 gpio_out  input  GPIO_W  observed SoC GPIO output bus.
REQ-010 ev_rd  input  1  pop request for the head event.
REQ-011 ev_valid  output  1  FIFO non-empty; head event valid.
REQ-012 ev_data  output  GPIO_W  GPIO value of the head event.
REQ-013 ev_time  output  TS_W  cycle-counter value at which the head event was sampled.
REQ-014 ev_overflow  output  1  sticky flag: at least one event dropped.
REQ-015 stop_req  output  1  sticky flag: STOP_CODE matched.
REQ-016 timeout  output  1  sticky flag: idle timeout expired.
REQ-017 state  output  2  FSM state: 0=ARM, 1=RUN, 2=STOP, 3=TOUT.

Function
REQ-018 Free-running cycle counter cyc (TS_W bits) SHALL increment every clock from 0 after reset and wrap modulo 2^TS_W in every state.
REQ-019 ARM: first edge after reset release SHALL load gpio_out into prev register, log nothing, go to RUN.
REQ-020 RUN: a change SHALL be gpio_out != prev at an edge; prev SHALL be updated with gpio_out on every RUN edge.
REQ-021 Each change SHALL push {gpio_out, cyc at that edge} into the FIFO; ev_valid visible the cycle after the sampling edge (1-cycle latency).
REQ-022 Push while full without simultaneous pop SHALL drop the new event, keep FIFO contents, set ev_overflow.
REQ-023 Push and pop on the same edge while full SHALL both succeed; no drop, no overflow.
REQ-024 ev_rd while FIFO empty SHALL be ignored; pointers wrap modulo FIFO_DEPTH; events leave in order.
REQ-025 Change where (gpio_out & STOP_MASK) == (STOP_CODE & STOP_MASK) SHALL be logged as normal, then state->STOP, stop_req=1 from the next cycle.
REQ-026 Idle counter SHALL reset to 0 on every RUN change and increment on every RUN edge without change, saturating.
REQ-027 When TIMEOUT_CYCLES != 0 and idle counter reaches TIMEOUT_CYCLES, state->TOUT and timeout=1 from the next cycle.
REQ-028 STOP and TOUT SHALL be terminal until reset: no further logging, flags held, FIFO still drainable via ev_rd.
REQ-029 Stop-match on the edge the idle counter would expire SHALL take priority: STOP entered, timeout stays 0.
REQ-030 Stop-match with FIFO full and no pop SHALL still enter STOP; the stop event is dropped and ev_overflow set.

Reset
REQ-031 rst high at an edge SHALL force state=ARM, cyc=0, idle=0, prev=0, FIFO empty (ev_valid=0), ev_data=0, ev_time=0, ev_overflow=0, stop_req=0, timeout=0.
REQ-032 rst asserted mid-run or in STOP/TOUT SHALL discard all queued events and restart from ARM on release.

Verification (GPIO_W=32, FIFO_DEPTH=4, TIMEOUT_CYCLES=16)
REQ-033 gpio_out 0 -> 32'hA5A5A5A5 sampled at cyc=5 -> ev_valid=1 next cycle, ev_data=A5A5A5A5, ev_time=5; ev_rd -> ev_valid=0.
REQ-034 Six distinct changes, no ev_rd -> first four retained in order, ev_overflow=1, remaining two absent.
REQ-035 FIFO full, change plus ev_rd on same edge -> head popped, new event at tail, ev_overflow=0.
REQ-036 gpio_out -> 32'hFFFFFFFF -> event logged, stop_req=1, state=2; later changes not logged.
REQ-037 No change for 16 consecutive RUN samples -> timeout=1, state=3; a 15-cycle idle gap followed by a change -> timeout=0.
REQ-038 rst pulsed in STOP with 3 queued events -> ev_valid=0, stop_req=0, state=0, then RUN one cycle after release.

Source files
------------

// File: rtl/soc_gpio_monitor.sv
// soc_gpio_monitor
//   Watches a SoC GPIO output bus and logs every change, together with the
//   cycle-counter value at which it was sampled, into a small event FIFO.
//   The run ends when the bus shows the stop pattern (STOP) or when the bus
//   stays idle for TIMEOUT_CYCLES samples (TOUT). Both end states hold until
//   reset, and the FIFO can still be drained from them.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   gpio_out    observed GPIO bus
//   ev_rd       pop the head event (ignored while empty)
//   ev_valid    FIFO non-empty
//   ev_data     GPIO value of the head event (0 while empty)
//   ev_time     cycle count of the head event (0 while empty)
//   ev_overflow sticky: an event was dropped because the FIFO was full
//   stop_req    sticky: stop pattern matched
//   timeout     sticky: idle timeout expired
//   state       0=ARM, 1=RUN, 2=STOP, 3=TOUT
module soc_gpio_monitor #(
  parameter int unsigned        GPIO_W         = 32,
  parameter logic [GPIO_W-1:0]  STOP_CODE      = '1,
  parameter logic [GPIO_W-1:0]  STOP_MASK      = '1,
  parameter int unsigned        FIFO_DEPTH     = 8,
  parameter int unsigned        TS_W           = 32,
  parameter int unsigned        TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GPIO_W-1:0] gpio_out,
  input  logic              ev_rd,
  output logic              ev_valid,
  output logic [GPIO_W-1:0] ev_data,
  output logic [TS_W-1:0]   ev_time,
  output logic              ev_overflow,
  output logic              stop_req,
  output logic              timeout,
  output logic [1:0]        state
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_ARM  = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;
  localparam logic [1:0] ST_TOUT = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [TS_W-1:0]   cyc_q;
  logic [IDLE_W-1:0] idle_q, idle_d, idle_inc;
  logic [GPIO_W-1:0] prev_q;
  logic [AW:0]       wr_q, rd_q;
  logic              ovf_q, stop_q, tout_q;

  logic [GPIO_W-1:0] mem_data [FIFO_DEPTH];
  logic [TS_W-1:0]   mem_time [FIFO_DEPTH];

  logic change, stop_hit, empty, full, pop, push, drop;

  always_comb begin
    change   = (state_q == ST_RUN) && (gpio_out != prev_q);
    stop_hit = change && ((gpio_out & STOP_MASK) == (STOP_CODE & STOP_MASK));
    empty    = (wr_q == rd_q);
    full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop      = ev_rd && !empty;
    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    push     = change && (!full || pop);
    drop     = change && full && !pop;
    idle_inc = (idle_q == '1) ? idle_q : idle_q + 1'b1;

    state_d = state_q;
    idle_d  = idle_q;
    case (state_q)
      ST_ARM: state_d = ST_RUN;
      ST_RUN: begin
        idle_d = change ? '0 : idle_inc;
        // Stop match wins; a change also clears idle, so the two never collide.
        if (stop_hit)
          state_d = ST_STOP;
        else if ((TIMEOUT_CYCLES != 0) && !change && (idle_inc == IDLE_W'(TIMEOUT_CYCLES)))
          state_d = ST_TOUT;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ARM;
      cyc_q   <= '0;
      idle_q  <= '0;
      prev_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
      stop_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      cyc_q   <= cyc_q + 1'b1;
      state_q <= state_d;
      idle_q  <= idle_d;
      if ((state_q == ST_ARM) || (state_q == ST_RUN))
        prev_q <= gpio_out;
      if (push)
        wr_q <= wr_q + 1'b1;
      if (pop)
        rd_q <= rd_q + 1'b1;
      if (drop)
        ovf_q <= 1'b1;
      if (state_d == ST_STOP)
        stop_q <= 1'b1;
      if (state_d == ST_TOUT)
        tout_q <= 1'b1;
    end
  end

  // Storage needs no reset: the output mux hides stale entries while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_q[AW-1:0]] <= gpio_out;
      mem_time[wr_q[AW-1:0]] <= cyc_q;
    end
  end

  always_comb begin
    ev_valid    = !empty;
    ev_data     = empty ? '0 : mem_data[rd_q[AW-1:0]];
    ev_time     = empty ? '0 : mem_time[rd_q[AW-1:0]];
    ev_overflow = ovf_q;
    stop_req    = stop_q;
    timeout     = tout_q;
    state       = state_q;
  end

endmodule

// File: tb/tb_soc_gpio_monitor.sv
module tb_soc_gpio_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] gpio_out = '0;
  logic        ev_rd = 1'b0;
  logic        ev_valid;
  logic [31:0] ev_data;
  logic [31:0] ev_time;
  logic        ev_overflow;
  logic        stop_req;
  logic        timeout;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    logic [31:0] t;
  } ev_t;
  ev_t sb[$];

  soc_gpio_monitor #(
    .GPIO_W(32),
    .STOP_CODE(32'hFFFF_FFFF),
    .STOP_MASK(32'hFFFF_FFFF),
    .FIFO_DEPTH(4),
    .TS_W(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .gpio_out(gpio_out),
    .ev_rd(ev_rd),
    .ev_valid(ev_valid),
    .ev_data(ev_data),
    .ev_time(ev_time),
    .ev_overflow(ev_overflow),
    .stop_req(stop_req),
    .timeout(timeout),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input logic [31:0] d, input logic [31:0] t);
    ev_t e;
    e.d = d;
    e.t = t;
    sb.push_back(e);
  endtask

  // Leaves rst low just after the last reset edge; next edge is the ARM edge (cyc=0).
  task automatic reset_dut();
    rst = 1'b1;
    ev_rd = 1'b0;
    gpio_out = '0;
    repeat (2) step();
    sb.delete();
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    ev_rd = 1'b1;
    repeat (n) step();
    ev_rd = 1'b0;
  endtask

  // Monitor: every accepted pop is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && ev_valid && ev_rd) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got data %0h time %0h expected none", ev_data, ev_time);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("ev_data", {32'h0, ev_data}, {32'h0, e.d});
        check("ev_time", {32'h0, ev_time}, {32'h0, e.t});
      end
    end
  end

  initial begin
    // Reset state
    reset_dut();
    check("rst_ev_valid", {63'h0, ev_valid}, 64'h0);
    check("rst_ev_data", {32'h0, ev_data}, 64'h0);
    check("rst_ev_time", {32'h0, ev_time}, 64'h0);
    check("rst_overflow", {63'h0, ev_overflow}, 64'h0);
    check("rst_stop_req", {63'h0, stop_req}, 64'h0);
    check("rst_timeout", {63'h0, timeout}, 64'h0);
    check("rst_state", {62'h0, state}, 64'h0);
    step();
    check("arm_to_run", {62'h0, state}, 64'h1);

    // Single change sampled at cyc=5
    repeat (4) step();
    gpio_out = 32'hA5A5_A5A5;
    expect_ev(32'hA5A5_A5A5, 32'd5);
    check("pre_sample_valid", {63'h0, ev_valid}, 64'h0);
    step();
    check("t1_ev_valid", {63'h0, ev_valid}, 64'h1);
    drain(1);
    check("t1_empty", {63'h0, ev_valid}, 64'h0);

    // Six changes, no reads: first four kept, overflow set
    reset_dut();
    step();
    for (int i = 1; i <= 6; i++) begin
      gpio_out = 32'(i);
      if (i <= 4) expect_ev(32'(i), 32'(i));
      step();
    end
    check("t2_overflow", {63'h0, ev_overflow}, 64'h1);
    drain(4);
    check("t2_empty", {63'h0, ev_valid}, 64'h0);
    drain(1);
    check("t2_rd_empty", {63'h0, ev_valid}, 64'h0);
    check("t2_state", {62'h0, state}, 64'h1);

    // Full FIFO with simultaneous push and pop
    reset_dut();
    step();
    for (int i = 1; i <= 4; i++) begin
      gpio_out = 32'(i);
      expect_ev(32'(i), 32'(i));
      step();
    end
    gpio_out = 32'd5;
    expect_ev(32'd5, 32'd5);
    drain(1);
    check("t3_overflow", {63'h0, ev_overflow}, 64'h0);
    drain(4);
    check("t3_empty", {63'h0, ev_valid}, 64'h0);

    // Stop pattern
    reset_dut();
    step();
    gpio_out = 32'hFFFF_FFFF;
    expect_ev(32'hFFFF_FFFF, 32'd1);
    step();
    check("t4_stop_req", {63'h0, stop_req}, 64'h1);
    check("t4_state", {62'h0, state}, 64'h2);
    gpio_out = 32'h12;
    step();
    gpio_out = 32'h34;
    step();
    drain(1);
    check("t4_no_more_events", {63'h0, ev_valid}, 64'h0);
    check("t4_stop_held", {63'h0, stop_req}, 64'h1);

    // Idle gap of 15 then change, then 16 idle samples -> timeout
    reset_dut();
    step();
    repeat (15) step();
    gpio_out = 32'h7;
    expect_ev(32'h7, 32'd16);
    step();
    check("t5_gap15_timeout", {63'h0, timeout}, 64'h0);
    check("t5_gap15_state", {62'h0, state}, 64'h1);
    drain(1);
    repeat (14) step();
    check("t5_idle15_timeout", {63'h0, timeout}, 64'h0);
    step();
    check("t5_timeout", {63'h0, timeout}, 64'h1);
    check("t5_state", {62'h0, state}, 64'h3);
    gpio_out = 32'h9;
    step();
    check("t5_tout_no_log", {63'h0, ev_valid}, 64'h0);

    // Stop with FIFO full and no pop: dropped, STOP entered
    reset_dut();
    step();
    for (int i = 1; i <= 4; i++) begin
      gpio_out = 32'(i);
      expect_ev(32'(i), 32'(i));
      step();
    end
    gpio_out = 32'hFFFF_FFFF;
    step();
    check("t6_state", {62'h0, state}, 64'h2);
    check("t6_overflow", {63'h0, ev_overflow}, 64'h1);
    check("t6_stop_req", {63'h0, stop_req}, 64'h1);
    drain(4);
    check("t6_empty", {63'h0, ev_valid}, 64'h0);

    // Reset in STOP with three queued events
    reset_dut();
    step();
    gpio_out = 32'h1;
    step();
    gpio_out = 32'h2;
    step();
    gpio_out = 32'hFFFF_FFFF;
    step();
    check("t7_state_stop", {62'h0, state}, 64'h2);
    check("t7_valid_before", {63'h0, ev_valid}, 64'h1);
    rst = 1'b1;
    step();
    sb.delete();
    check("t7_rst_valid", {63'h0, ev_valid}, 64'h0);
    check("t7_rst_stop", {63'h0, stop_req}, 64'h0);
    check("t7_rst_state", {62'h0, state}, 64'h0);
    rst = 1'b0;
    gpio_out = '0;
    step();
    check("t7_run", {62'h0, state}, 64'h1);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover_events: got %0d expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
